// File: rtl/svm_cfg_loader_if.sv
// svm_cfg_loader_if: host stream and coefficient-RAM port A between the loader and its environment
// Signals: s_valid/s_ready/s_data/s_last carry the host stream; addr_a/write_en/i_data/o_data_a are RAM port A.
// Modports: master is the loader side, slave is the host/RAM side.
interface svm_cfg_loader_if #(
    parameter int COEF_W = 12,
    parameter int N_COEF = 105,
    parameter int ADDR_W = 6
);
    localparam int RAM_DW = COEF_W * N_COEF;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [COEF_W-1:0] s_data;
    logic [ADDR_W-1:0] addr_a;
    logic              write_en;
    logic [RAM_DW-1:0] i_data;
    logic [RAM_DW-1:0] o_data_a;
    modport master (input s_valid, s_data, s_last, o_data_a, output s_ready, addr_a, write_en, i_data);
    modport slave (output s_valid, s_data, s_last, o_data_a, input s_ready, addr_a, write_en, i_data);
endinterface

// File: rtl/svm_cfg_loader.sv
// svm_cfg_loader: loads bias + N_ROW x N_COEF coefficients into the coefficient RAM, then verifies by XOR readback
// Ports: clk; rst (asynchronous, active-low); start begins a load when not busy;
//        bus = host stream in + RAM port A out; bias/b_load feed the classifier;
//        busy during load/verify, done (sticky) after a clean verify, error (sticky) on framing or checksum failure.
module svm_cfg_loader #(
    parameter int COEF_W = 12,
    parameter int N_COEF = 105,
    parameter int N_ROW  = 36,
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    svm_cfg_loader_if.master  bus,
    output logic [COEF_W-1:0] bias,
    output logic              b_load,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int RAM_DW = COEF_W * N_COEF;
    localparam int CW = $clog2(N_COEF + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROW - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N_COEF - 1);
    localparam logic [CW-1:0] LAST_ISS = CW'(N_ROW - 1);
    localparam logic [CW-1:0] VER_END = CW'(N_ROW + RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, BIAS, LOAD, WRITE, VERIFY, CHECK, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d, addr_q, addr_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RAM_DW-1:0] pack_q, pack_d;
    logic [COEF_W-1:0] chk_wr_q, chk_wr_d, chk_rd_q, chk_rd_d, bias_q, bias_d, fold;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              we_q, we_d, b_load_q, b_load_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              hs, sum_ok;

    assign bus.s_ready  = (state_q == BIAS) || (state_q == LOAD);
    assign bus.addr_a   = addr_q;
    assign bus.write_en = we_q;
    assign bus.i_data   = pack_q;
    assign bias         = bias_q;
    assign b_load       = b_load_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign hs           = bus.s_valid && bus.s_ready;
    assign sum_ok       = chk_rd_q == chk_wr_q;

    always_comb begin
        fold = '0;
        for (int i = 0; i < N_COEF; i++) fold ^= bus.o_data_a[COEF_W*i +: COEF_W];
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        addr_d   = addr_q;
        pack_d   = pack_q;
        chk_wr_d = chk_wr_q;
        chk_rd_d = chk_rd_q;
        bias_d   = bias_q;
        we_d     = 1'b0;
        b_load_d = 1'b0;
        done_d   = done_q;
        error_d  = error_q;
        // col doubles as the VERIFY cycle counter; a read is tagged while addresses 0..N_ROW-1 are issued
        vld_d = (vld_q << 1) | RD_LAT'(state_q == VERIFY && col_q <= LAST_ISS);
        if (vld_q[RD_LAT-1]) chk_rd_d = chk_rd_q ^ fold;
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d  = BIAS;
                row_d    = '0;
                col_d    = '0;
                chk_wr_d = '0;
                chk_rd_d = '0;
                done_d   = 1'b0;
                error_d  = 1'b0;
            end
            BIAS: if (hs) begin
                state_d  = bus.s_last ? ERR : LOAD;
                error_d  = bus.s_last;
                bias_d   = bus.s_last ? bias_q : bus.s_data;
                b_load_d = !bus.s_last;
            end
            LOAD: if (hs) begin
                pack_d[COEF_W*col_q +: COEF_W] = bus.s_data;
                chk_wr_d = chk_wr_q ^ bus.s_data;
                col_d    = col_q + 1'b1;
                if (bus.s_last != (row_q == LAST_ROW && col_q == LAST_COL)) begin
                    state_d = ERR;
                    error_d = 1'b1;
                end else if (col_q == LAST_COL) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    addr_d  = row_q;
                end
            end
            WRITE: begin
                col_d   = '0;
                addr_d  = '0;
                row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
                state_d = (row_q == LAST_ROW) ? VERIFY : LOAD;
            end
            VERIFY: begin
                addr_d  = (col_q < LAST_ISS) ? addr_q + 1'b1 : '0;
                col_d   = (col_q == VER_END) ? '0 : col_q + 1'b1;
                state_d = (col_q == VER_END) ? CHECK : VERIFY;
            end
            CHECK: begin
                done_d  = sum_ok;
                error_d = !sum_ok;
                state_d = sum_ok ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
        busy_d = !(state_d inside {IDLE, DONE, ERR});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            addr_q   <= '0;
            pack_q   <= '0;
            chk_wr_q <= '0;
            chk_rd_q <= '0;
            bias_q   <= '0;
            vld_q    <= '0;
            we_q     <= 1'b0;
            b_load_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            addr_q   <= addr_d;
            pack_q   <= pack_d;
            chk_wr_q <= chk_wr_d;
            chk_rd_q <= chk_rd_d;
            bias_q   <= bias_d;
            vld_q    <= vld_d;
            we_q     <= we_d;
            b_load_q <= b_load_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end
endmodule

// File: doc/svm_cfg_loader.md
Name: svm_cfg_loader

Overview:
- Configuration sequencer for the SVM classifier.
- Accepts a narrow host stream (bias, then 36 rows x 105 coefficients) and loads the result into the classifier.
- Packs each row's coefficients into one 1260-bit coefficient-RAM word and writes it through RAM port A.
- After the last row, reads all rows back and compares an XOR checksum, then raises done or error; downstream logic holds HOG traffic off until done.

Parameters:
- COEF_W, 12, coefficient and bias width (FEA_I+FEA_F).
- N_COEF, 105, coefficients per RAM row (15x7).
- N_ROW, 36, RAM rows per model.
- ADDR_W, 6, RAM address width.
- RD_LAT, 1, RAM port-A read latency in cycles (1..3).
- Derived RAM_DW = COEF_W*N_COEF.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a load; honoured only when not busy.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid&s_ready.
- s_data  in  COEF_W  stream word (two's complement).
- s_last  in  1  marks the final coefficient of the final row.
- addr_a  out  ADDR_W  RAM port-A address.
- write_en  out  1  RAM port-A write strobe.
- i_data  out  RAM_DW  RAM write data.
- o_data_a  in  RAM_DW  RAM port-A read data.
- bias  out  COEF_W  bias value to classifier.
- b_load  out  1  one-cycle bias load strobe.
- busy  out  1  load or verify in progress.
- done  out  1  model loaded and verified; sticky.
- error  out  1  framing or checksum failure; sticky.

Behaviour:
Reset:
- All outputs and internal registers are 0; state is IDLE.
- Asynchronous assertion mid-load aborts immediately. No partial write strobe is issued after reset asserts.

Outputs:
- All outputs are registered except s_ready, which decodes the current state.
- busy=1 in every state except IDLE, DONE and ERR.

States:
- IDLE: s_ready=0. start -> BIAS.
- DONE, ERR: s_ready=0. start -> BIAS; clears done and error in the same cycle.
- start while busy: ignored.
- BIAS: s_ready=1. On handshake: bias<=s_data, b_load=1 in the next cycle only, then -> LOAD. s_last=1 on this word -> ERR (b_load not pulsed).
- LOAD: s_ready=1. Handshake k (col 0..104) places s_data at pack[COEF_W*col +: COEF_W] and XORs it into chk_wr. Handshake at col=104 -> WRITE.
- Framing errors in LOAD, all -> ERR:
  - s_last=1 before (row 35, col 104).
  - s_last=0 at (row 35, col 104).
- WRITE: s_ready=0. For exactly one cycle: write_en=1, addr_a=row, i_data=pack. Then col<=0.
  - If row<35: row++ and -> LOAD.
  - If row=35: row<=0 and -> VERIFY.
- VERIFY: write_en=0.
  - Issue addr_a=0..35 on consecutive cycles.
  - Each issued address is tagged via an RD_LAT-deep valid shift line.
  - When a tag emerges, the XOR-fold of all 105 fields of o_data_a is XORed into chk_rd.
  - Lasts N_ROW+RD_LAT cycles, then -> CHECK.
- CHECK: one cycle. chk_rd==chk_wr -> DONE (done=1); else -> ERR (error=1).
- ERR: write_en forced 0; no further RAM writes or b_load.

Arithmetic and stream rules:
- The checksum covers coefficients only; the bias is excluded.
- Checksums are COEF_W wide, pure XOR, no carries.
- Stream gaps (s_valid=0) stall LOAD/BIAS indefinitely, with no timeout.
- Words presented while s_ready=0 are neither consumed nor flagged.

Timing (zero-stall, RD_LAT=1, start sampled cycle 0):
- Bias handshake: cycle 1.
- Row r write: cycle 107+106r.
- Last write: cycle 3817.
- done=1 from cycle 3856.

Test Plan:
- Zero-stall load, coef = (106*row+col) mod 4096, bias=0xF80, behavioural RAM (RD_LAT=1) -> b_load once with bias=0xF80; 36 writes at addr 0..35 with matching fields; done=1 at cycle 3856; error=0.
- Same data with random s_valid gaps (30%) and RD_LAT=3 -> identical RAM contents; done=1; busy falls the same cycle done rises.
- Framing errors:
  - s_last=1 at row 3, col 10 -> error=1 next cycle; exactly 3 writes issued; no further s_ready.
  - Separate run, s_last=0 at the final word -> error=1.
- RAM model flips bit 5 of row 17 on readback -> checksum mismatch; error=1, done=0.
- rst low during LOAD of row 20 -> all outputs 0 immediately.
  - After release, new start plus full stream -> done=1 with the new contents.
- start pulsed during LOAD and VERIFY -> ignored.
  - start after DONE -> done clears the same cycle and a second load completes.
